regfile: RTL

- 32-entry general-purpose register file for the 5-stage MIPS core.
- Sits downstream of the memory stage, at writeback. It consumes the w_reg_addr / w_reg_data / w_reg_en triple the memory stage forwards.
- Serves two independent read ports to the decode stage.
- Register $0 is hardwired to zero. A same-cycle write-to-read bypass lets decode see writeback data without a stall.

---
 rtl/regfile.sv | 71 +++++++
 1 files changed

// File: rtl/regfile.sv
// 32-entry MIPS general-purpose register file: async active-low clear, hardwired $0,
// two combinational read ports with optional same-cycle writeback forwarding.
`ifndef REG_ADDR_WIDTH
`define REG_ADDR_WIDTH 5
`endif
`ifndef REG_DATA_WIDTH
`define REG_DATA_WIDTH 32
`endif

module regfile #(
    parameter int REG_NUM   = 32,
    parameter bit BYPASS_EN = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       w_reg_en,
    input  logic [`REG_ADDR_WIDTH-1:0] w_reg_addr,
    input  logic [`REG_DATA_WIDTH-1:0] w_reg_data,
    input  logic                       r1_en,
    input  logic [`REG_ADDR_WIDTH-1:0] r1_addr,
    output logic [`REG_DATA_WIDTH-1:0] r1_data,
    input  logic                       r2_en,
    input  logic [`REG_ADDR_WIDTH-1:0] r2_addr,
    output logic [`REG_DATA_WIDTH-1:0] r2_data
);

    localparam int AW = `REG_ADDR_WIDTH;
    localparam int DW = `REG_DATA_WIDTH;

    logic [DW-1:0] regs [REG_NUM];
    logic          fwd1;
    logic          fwd2;

    // Entry 0 is never written, so it holds the reset value of zero forever.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < REG_NUM; i++) begin
                regs[i] <= '0;
            end
        end else if (w_reg_en && (w_reg_addr != '0)) begin
            regs[w_reg_addr] <= w_reg_data;
        end
    end

    assign fwd1 = BYPASS_EN && w_reg_en && (w_reg_addr == r1_addr);
    assign fwd2 = BYPASS_EN && w_reg_en && (w_reg_addr == r2_addr);

    // The zero-address check precedes forwarding so a write to $0 never leaks out.
    always_comb begin
        r1_data = '0;
        if (rst_n && r1_en && (r1_addr != {AW{1'b0}})) begin
            if (fwd1) begin
                r1_data = w_reg_data;
            end else begin
                r1_data = regs[r1_addr];
            end
        end
    end

    always_comb begin
        r2_data = '0;
        if (rst_n && r2_en && (r2_addr != {AW{1'b0}})) begin
            if (fwd2) begin
                r2_data = w_reg_data;
            end else begin
                r2_data = regs[r2_addr];
            end
        end
    end

endmodule
